// File: rtl/tone_sample_writer.sv
// Square-wave tone generator with linear attack/release envelope feeding the
// Audio_Controller DAC FIFO; phase and envelope step only on accepted samples.
module tone_sample_writer #(
    parameter int          HP_W     = 19,
    parameter logic [31:0] AMP_MAX  = 32'd100000000,
    parameter logic [31:0] AMP_STEP = 32'd390625
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            tone_en,
    input  logic [HP_W-1:0] half_period,
    input  logic            audio_out_allowed,
    output logic            write_audio_out,
    output logic [31:0]     left_channel_audio_out,
    output logic [31:0]     right_channel_audio_out,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [31:0]     amp_reg, amp_next;
    logic            polarity_reg, polarity_next;
    logic [HP_W-1:0] half_cnt_reg, half_cnt_next;
    logic [HP_W-1:0] hp_lat_reg, hp_lat_next;
    logic [31:0]     sample_reg, sample_next;
    logic            busy_reg, busy_next;
    logic            write_reg;

    logic            acc;
    logic [32:0]     amp_up;
    logic [31:0]     amp_up_sat;

    assign acc = write_reg & audio_out_allowed;

    // One extra bit keeps the attack sum from wrapping before saturation.
    assign amp_up     = {1'b0, amp_reg} + {1'b0, AMP_STEP};
    assign amp_up_sat = (amp_up >= {1'b0, AMP_MAX}) ? AMP_MAX : amp_up[31:0];

    always_comb begin
        state_next    = state_reg;
        amp_next      = amp_reg;
        polarity_next = polarity_reg;
        half_cnt_next = half_cnt_reg;
        hp_lat_next   = hp_lat_reg;
        sample_next   = sample_reg;
        busy_next     = busy_reg;

        if (acc) begin
            case (state_reg)
                ST_IDLE: begin
                    if (tone_en) begin
                        state_next    = ST_ATTACK;
                        amp_next      = AMP_STEP;
                        polarity_next = 1'b1;
                        half_cnt_next = '0;
                        hp_lat_next   = half_period;
                    end
                end
                ST_ATTACK: begin
                    if (!tone_en) begin
                        state_next = ST_RELEASE;
                    end else if (amp_up >= {1'b0, AMP_MAX}) begin
                        amp_next   = AMP_MAX;
                        state_next = ST_SUSTAIN;
                    end else begin
                        amp_next = amp_up[31:0];
                    end
                end
                ST_SUSTAIN: begin
                    amp_next = AMP_MAX;
                    if (!tone_en) begin
                        state_next = ST_RELEASE;
                    end
                end
                default: begin
                    // A retrigger ramps back up from wherever the release got to.
                    if (tone_en) begin
                        state_next = ST_ATTACK;
                        amp_next   = amp_up_sat;
                    end else if (amp_reg <= AMP_STEP) begin
                        amp_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        amp_next = amp_reg - AMP_STEP;
                    end
                end
            endcase

            if (state_reg != ST_IDLE) begin
                if (hp_lat_reg == '0) begin
                    half_cnt_next = '0;
                    hp_lat_next   = half_period;
                end else if (half_cnt_reg >= hp_lat_reg - HP_W'(1)) begin
                    half_cnt_next = '0;
                    polarity_next = ~polarity_reg;
                    hp_lat_next   = half_period;
                end else begin
                    half_cnt_next = half_cnt_reg + HP_W'(1);
                end
            end

            if (state_next == ST_IDLE || hp_lat_next == '0) begin
                sample_next = '0;
            end else if (polarity_next) begin
                sample_next = amp_next;
            end else begin
                sample_next = -amp_next;
            end
            busy_next = (state_next != ST_IDLE);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            amp_reg      <= '0;
            polarity_reg <= 1'b1;
            half_cnt_reg <= '0;
            hp_lat_reg   <= '0;
            sample_reg   <= '0;
            busy_reg     <= 1'b0;
            write_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            amp_reg      <= amp_next;
            polarity_reg <= polarity_next;
            half_cnt_reg <= half_cnt_next;
            hp_lat_reg   <= hp_lat_next;
            sample_reg   <= sample_next;
            busy_reg     <= busy_next;
            write_reg    <= 1'b1;
        end
    end

    assign write_audio_out         = write_reg;
    assign left_channel_audio_out  = sample_reg;
    assign right_channel_audio_out = sample_reg;
    assign busy                    = busy_reg;

endmodule

// File: tb/tb_tone_sample_writer.sv
// Directed bench for tone_sample_writer using a small envelope (AMP_MAX=1000,
// AMP_STEP=250) so every expected sample can be worked out by hand.
module tb_tone_sample_writer;

    localparam int HP_W = 19;

    logic            CLOCK_50 = 1'b0;
    logic            resetn = 1'b0;
    logic            tone_en = 1'b0;
    logic [HP_W-1:0] half_period = '0;
    logic            audio_out_allowed = 1'b1;
    logic            write_audio_out;
    logic [31:0]     left_channel_audio_out;
    logic [31:0]     right_channel_audio_out;
    logic            busy;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    tone_sample_writer #(
        .HP_W    (HP_W),
        .AMP_MAX (32'd1000),
        .AMP_STEP(32'd250)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .resetn                 (resetn),
        .tone_en                (tone_en),
        .half_period            (half_period),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy                   (busy)
    );

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'd0 ||
                right_channel_audio_out !== 32'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: wr=%b l=%0d r=%0d busy=%b, want wr=0 l=0 r=0 busy=0",
                         i, write_audio_out, $signed(left_channel_audio_out),
                         $signed(right_channel_audio_out), busy);
            end else $display("[TB] reset_hold[%0d] ok", i);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (write_audio_out !== 1'b1 || left_channel_audio_out !== 32'd0 ||
                right_channel_audio_out !== 32'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle[%0d]: wr=%b l=%0d r=%0d busy=%b, want wr=1 l=0 r=0 busy=0",
                         i, write_audio_out, $signed(left_channel_audio_out),
                         $signed(right_channel_audio_out), busy);
            end else $display("[TB] idle[%0d] ok", i);
        end
    endtask

    task automatic test_attack_sustain;
        int exp_s[9] = '{250, 500, -750, -1000, 1000, 1000, -1000, -1000, 1000};
        tone_en     = 1'b1;
        half_period = 19'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_s[i] ||
                $signed(right_channel_audio_out) !== exp_s[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL attack[%0d]: l=%0d r=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), $signed(right_channel_audio_out),
                         busy, exp_s[i]);
            end else $display("[TB] attack[%0d] sample=%0d", i, exp_s[i]);
        end
    endtask

    task automatic test_release;
        int   exp_s[6] = '{1000, -750, -500, 250, 0, 0};
        logic exp_b[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tone_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_s[i] ||
                $signed(right_channel_audio_out) !== exp_s[i] || busy !== exp_b[i]) begin
                fails++;
                $display("FAIL release[%0d]: l=%0d r=%0d busy=%b, want %0d busy=%b", i,
                         $signed(left_channel_audio_out), $signed(right_channel_audio_out),
                         busy, exp_s[i], exp_b[i]);
            end else $display("[TB] release[%0d] sample=%0d", i, exp_s[i]);
        end
    endtask

    task automatic test_backpressure;
        int exp_a[2] = '{250, 500};
        int exp_r[3] = '{-750, -1000, 1000};
        tone_en     = 1'b1;
        half_period = 19'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_a[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_pre[%0d]: l=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), busy, exp_a[i]);
            end else $display("[TB] bp_pre[%0d] sample=%0d", i, exp_a[i]);
        end
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) tone_en = 1'b0;
            if (i == 6) tone_en = 1'b1;
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== 500 ||
                $signed(right_channel_audio_out) !== 500 ||
                busy !== 1'b1 || write_audio_out !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: l=%0d r=%0d busy=%b wr=%b, want 500 busy=1 wr=1", i,
                         $signed(left_channel_audio_out), $signed(right_channel_audio_out),
                         busy, write_audio_out);
            end else $display("[TB] bp_hold[%0d] sample=500", i);
        end
        audio_out_allowed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_r[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_resume[%0d]: l=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), busy, exp_r[i]);
            end else $display("[TB] bp_resume[%0d] sample=%0d", i, exp_r[i]);
        end
    endtask

    task automatic test_pitch_change;
        int exp_p[6] = '{1000, -1000, -1000, -1000, -1000, 1000};
        int exp_z[6] = '{1000, 1000, 1000, 0, 0, 0};
        int exp_b[3] = '{-1000, -1000, 1000};
        half_period = 19'd4;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_p[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL pitch[%0d]: l=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), busy, exp_p[i]);
            end else $display("[TB] pitch[%0d] sample=%0d", i, exp_p[i]);
        end
        half_period = 19'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_z[i] ||
                $signed(right_channel_audio_out) !== exp_z[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL zero_hp[%0d]: l=%0d r=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), $signed(right_channel_audio_out),
                         busy, exp_z[i]);
            end else $display("[TB] zero_hp[%0d] sample=%0d", i, exp_z[i]);
        end
        half_period = 19'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_b[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL hp_back[%0d]: l=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), busy, exp_b[i]);
            end else $display("[TB] hp_back[%0d] sample=%0d", i, exp_b[i]);
        end
    endtask

    task automatic test_async_reset;
        #3;
        resetn  = 1'b0;
        tone_en = 1'b0;
        #1;
        tests++;
        if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'd0 ||
            right_channel_audio_out !== 32'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: wr=%b l=%0d r=%0d busy=%b, want all 0",
                     write_audio_out, $signed(left_channel_audio_out),
                     $signed(right_channel_audio_out), busy);
        end else $display("[TB] async_reset outputs cleared between edges");
        tick();
        resetn = 1'b1;
        tick();
        tests++;
        if (write_audio_out !== 1'b1 || left_channel_audio_out !== 32'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: wr=%b l=%0d busy=%b, want wr=1 l=0 busy=0",
                     write_audio_out, $signed(left_channel_audio_out), busy);
        end else $display("[TB] post_reset ok");
    endtask

    task automatic test_retrigger;
        int exp_s[9] = '{250, 500, -750, -1000, 1000, 750, -500, -750, 1000};
        for (int i = 0; i < 9; i++) begin
            if (i == 0) tone_en = 1'b1;
            if (i == 4) tone_en = 1'b0;
            if (i == 7) tone_en = 1'b1;
            tick();
            tests++;
            if ($signed(left_channel_audio_out) !== exp_s[i] ||
                $signed(right_channel_audio_out) !== exp_s[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL retrigger[%0d]: l=%0d r=%0d busy=%b, want %0d busy=1", i,
                         $signed(left_channel_audio_out), $signed(right_channel_audio_out),
                         busy, exp_s[i]);
            end else $display("[TB] retrigger[%0d] sample=%0d", i, exp_s[i]);
        end
    endtask

    initial begin
        test_reset();
        test_attack_sustain();
        test_release();
        test_backpressure();
        test_pitch_change();
        test_async_reset();
        test_retrigger();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tone_sample_writer.md
Name: tone_sample_writer

Overview:
- Sample-generation stage between the lobby/game melody logic and Audio_Controller's DAC side.
- Converts a gate (tone_en) plus a half-period value (counted in audio samples) into a 32-bit signed square-wave sample stream.
- Applies a linear attack/release envelope so notes start and stop without clicks.
- Drives left/right_channel_audio_out and write_audio_out, and obeys audio_out_allowed backpressure. Phase and envelope advance only on accepted samples, so pitch is tied to the codec sample rate and does not depend on CLOCK_50.

Parameters:
- HP_W, 19: width of half_period.
- AMP_MAX, 100000000: peak envelope amplitude. Must be less than 2^31.
- AMP_STEP, 390625: amplitude change per accepted sample during attack and release (256 steps from 0 to AMP_MAX).

Ports:
- CLOCK_50, input, 1: system clock. All logic is on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- tone_en, input, 1: note gate. 1 means sound the note, 0 means release it.
- half_period, input, HP_W: accepted samples per half cycle of the square wave. 0 means silent note.
- audio_out_allowed, input, 1: Audio_Controller output FIFO has space.
- write_audio_out, output, 1: sample valid / write strobe.
- left_channel_audio_out, output, 32: signed sample.
- right_channel_audio_out, output, 32: signed sample, always identical to left.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, amp=0, polarity=1, half_cnt=0, hp_lat=0.
  - Both sample outputs=0, write_audio_out=0, busy=0.
- write_audio_out:
  - Registered. Goes to 1 on the first clock edge after resetn deasserts and stays 1 until the next reset.
  - The stream is continuous: in IDLE the stream is zeros.
- Accept event: acc = write_audio_out & audio_out_allowed.
  - All state, envelope and phase updates below happen only on a clock with acc=1.
  - When acc=0, outputs and all internal registers hold.
- Output sample (registered, updated on acc, using next-state values):
  - 0 if state is IDLE or hp_lat=0.
  - Otherwise +amp if polarity=1, else -amp (32-bit two's complement).
  - Left and right are always equal.
- Envelope FSM, evaluated on acc only:
  - IDLE:
    - tone_en=1: go to ATTACK, amp=AMP_STEP, polarity=1, half_cnt=0, hp_lat=half_period.
    - tone_en=0: stay in IDLE.
  - ATTACK:
    - tone_en=0: go to RELEASE, amp unchanged this sample.
    - Else if amp+AMP_STEP >= AMP_MAX: amp=AMP_MAX, go to SUSTAIN.
    - Else: amp += AMP_STEP.
  - SUSTAIN:
    - amp=AMP_MAX.
    - tone_en=0: go to RELEASE.
  - RELEASE:
    - tone_en=1: go to ATTACK. Amp continues from its current value; phase is not reset.
    - Else if amp <= AMP_STEP: amp=0, go to IDLE.
    - Else: amp -= AMP_STEP.
- Amplitude arithmetic:
  - Compute in 32 bits unsigned.
  - Saturate at AMP_MAX and at 0. Never wrap.
- Phase, in any state except IDLE, on acc:
  - If hp_lat=0: half_cnt=0, polarity held, hp_lat=half_period (picks up a new nonzero value on the next accept).
  - Else if half_cnt >= hp_lat-1: half_cnt=0, polarity toggles, hp_lat=half_period (new pitch takes effect only at a half-cycle boundary; no glitch).
  - Else: half_cnt += 1.
- busy: registered, equals (state != IDLE) after the update.
- Simultaneous events:
  - tone_en change while acc=0 has no effect until the next acc.
  - A tone_en toggle within one sample is evaluated as sampled on the acc clock.
- Reset mid-note: outputs go to 0 asynchronously. There is no release ramp.

Test Plan (AMP_MAX=1000, AMP_STEP=250, audio_out_allowed=1 unless stated):
1. Reset and idle:
   - Stimulus: resetn low 3 cycles, then high; tone_en=0.
   - Required: outputs 0 and write_audio_out=0 during reset; write_audio_out=1 from the 1st edge after release; samples stay 0; busy=0.
2. Attack, sustain and square wave:
   - Stimulus: tone_en=1, half_period=2.
   - Required sample sequence: +250, +500, -750, -1000, +1000, +1000, -1000, ...; busy=1 from the first sample.
3. Release:
   - Stimulus: from SUSTAIN with half_period=2, drop tone_en.
   - Required magnitudes: 1000, 750, 500, 250, 0, with sign continuing to follow the phase; then IDLE, busy=0, samples 0.
4. Backpressure:
   - Stimulus: hold audio_out_allowed=0 for 10 cycles in mid-attack.
   - Required: sample, amp, half_cnt and polarity frozen; sequence resumes exactly where it stopped when allowed returns to 1.
5. Pitch change and zero period:
   - Stimulus: change half_period from 2 to 4 mid half-cycle.
   - Required: current half-cycle finishes at 2 samples, next is 4 samples.
   - Stimulus: set half_period=0.
   - Required: samples 0, busy=1.
6. Async reset mid-note and retrigger:
   - Stimulus: assert resetn low between clock edges during SUSTAIN.
   - Required: outputs 0 immediately.
   - Stimulus: retrigger tone_en during RELEASE at amp=500.
   - Required: next sample magnitude 750, state ATTACK.
